// File: rtl/exe_mul_stage.sv
// exe_mul_stage: ALU/branch execute stage with an optional iterative shift-add multiplier.
//   Build option: define EXE_MUL_STAGE_MUL_EN to enable MUL/MLA; otherwise
//   1010/1011 behave as undefined codes and ready_out is tied high.
//   Ports:
//     CLK, RST (async, active-low)  clock and reset
//     valid_in / ready_out          op handshake, accepted when both high
//     flush                         cancels the in-flight op, blocks acceptance
//     EXE_CMD, S, SR_In             operation, flag-update enable, incoming {N,Z,C,V}
//     MEM_R_EN, MEM_W_EN            select 12-bit address offset as second operand
//     PC, Val_Rn, Val_Rm, Val_Ra    operands (Val_Ra is the MLA accumulator)
//     Shift_operand, imm            shifter / immediate encoding
//     Signed_EX_imm                 branch offset in words
//     valid_out, ALU_Result, Branch_Address, SR_Out, SR_WE  registered results
module exe_mul_stage #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             flush,
    input  logic [3:0]       EXE_CMD,
    input  logic             S,
    input  logic [3:0]       SR_In,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] Val_Rn,
    input  logic [WIDTH-1:0] Val_Rm,
    input  logic [WIDTH-1:0] Val_Ra,
    input  logic [11:0]      Shift_operand,
    input  logic             imm,
    input  logic [IMM_W-1:0] Signed_EX_imm,
    output logic             valid_out,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] Branch_Address,
    output logic [3:0]       SR_Out,
    output logic             SR_WE
);

    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input int unsigned n);
        logic [2*WIDTH-1:0] d;
        d = {x, x} >> (n % WIDTH);
        return d[WIDTH-1:0];
    endfunction

    logic [4:0]              w_sh;
    logic signed [WIDTH-1:0] w_asr;
    logic [WIDTH-1:0]        w_shifted;
    logic [WIDTH-1:0]        w_val2;
    logic [WIDTH-1:0]        w_ba;
    logic                    w_sub;
    logic                    w_cin;
    logic [WIDTH-1:0]        w_bop;
    logic [WIDTH:0]          w_sum;
    logic                    w_v;
    logic [WIDTH-1:0]        w_res;
    logic [3:0]              w_flags;
    logic                    w_is_mul;
    logic                    w_fire;
    logic                    w_done;
    logic                    w_done_s;
    logic [WIDTH-1:0]        w_done_res;
    logic [WIDTH-1:0]        w_done_ba;
    logic [3:0]              w_done_flags;

    assign w_sh  = Shift_operand[11:7];
    // Kept as its own signed net so the shift stays arithmetic.
    assign w_asr = $signed(Val_Rm) >>> w_sh;

    assign w_shifted = (Shift_operand[6:5] == 2'b00) ? Val_Rm << w_sh :
                       (Shift_operand[6:5] == 2'b01) ? Val_Rm >> w_sh :
                       (Shift_operand[6:5] == 2'b10) ? w_asr :
                                                       ror(Val_Rm, 32'(w_sh));

    assign w_val2 = imm                   ? ror(WIDTH'(Shift_operand[7:0]), 32'(Shift_operand[11:8]) * 2) :
                    (MEM_R_EN | MEM_W_EN) ? WIDTH'(Shift_operand) :
                                            w_shifted;

    assign w_ba = PC + ({{(WIDTH-IMM_W){Signed_EX_imm[IMM_W-1]}}, Signed_EX_imm} << 2);

    // Subtraction is a + ~b + carry-in, so C comes out as "no borrow".
    assign w_sub = EXE_CMD inside {4'b0100, 4'b0101};
    assign w_cin = (EXE_CMD inside {4'b0011, 4'b0101}) ? SR_In[1] : (EXE_CMD == 4'b0100);
    assign w_bop = w_sub ? ~w_val2 : w_val2;
    assign w_sum = {1'b0, Val_Rn} + {1'b0, w_bop} + (WIDTH+1)'(w_cin);
    assign w_v   = (Val_Rn[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != Val_Rn[WIDTH-1]);

    always_comb begin
        w_res = '0;
        case (EXE_CMD)
            4'b0001: w_res = w_val2;
            4'b1001: w_res = ~w_val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: w_res = w_sum[WIDTH-1:0];
            4'b0110: w_res = Val_Rn & w_val2;
            4'b0111: w_res = Val_Rn | w_val2;
            4'b1000: w_res = Val_Rn ^ w_val2;
            default: w_res = '0;
        endcase
    end

    assign w_flags = (EXE_CMD inside {[4'd2:4'd5]})           ? {w_res[WIDTH-1], w_res == '0, w_sum[WIDTH], w_v} :
                     (EXE_CMD inside {4'd1, [4'd6:4'd9]})     ? {w_res[WIDTH-1], w_res == '0, SR_In[1:0]} :
                                                                SR_In;

`ifdef EXE_MUL_STAGE_MUL_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_s;
    logic [1:0]       r_cv;
    logic [WIDTH-1:0] r_ba;

    assign ready_out    = (r_state == S_IDLE);
    assign w_is_mul     = (EXE_CMD[3:1] == 3'b101);
    assign w_done       = (r_state == S_DONE) && !flush;
    assign w_done_s     = r_s;
    assign w_done_res   = r_acc;
    assign w_done_ba    = r_ba;
    assign w_done_flags = {r_acc[WIDTH-1], r_acc == '0, r_cv};

    // One multiplier bit per cycle: add the shifted multiplicand when the low bit is set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_s      <= 1'b0;
            r_cv     <= '0;
            r_ba     <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (valid_in && w_is_mul) begin
                r_state  <= S_MUL;
                r_cnt    <= '0;
                r_acc    <= EXE_CMD[0] ? Val_Ra : '0;
                r_mcand  <= Val_Rn;
                r_mplier <= w_val2;
                r_s      <= S;
                r_cv     <= SR_In[1:0];
                r_ba     <= w_ba;
            end
        end else if (r_state == S_MUL) begin
            if (r_mplier[0])
                r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH-1))
                r_state <= S_DONE;
        end else begin
            r_state <= S_IDLE;
        end
    end
`else
    logic w_unused;

    assign w_unused     = ^Val_Ra;
    assign ready_out    = 1'b1;
    assign w_is_mul     = 1'b0;
    assign w_done       = 1'b0;
    assign w_done_s     = 1'b0;
    assign w_done_res   = '0;
    assign w_done_ba    = '0;
    assign w_done_flags = '0;
`endif

    assign w_fire = valid_in && ready_out && !flush && !w_is_mul;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_out      <= 1'b0;
            SR_WE          <= 1'b0;
            ALU_Result     <= '0;
            Branch_Address <= '0;
            SR_Out         <= '0;
        end else begin
            valid_out <= w_fire || w_done;
            SR_WE     <= (w_fire && S) || (w_done && w_done_s);
            if (w_fire) begin
                ALU_Result     <= w_res;
                Branch_Address <= w_ba;
            end else if (w_done) begin
                ALU_Result     <= w_done_res;
                Branch_Address <= w_done_ba;
            end
            if (w_fire && S)
                SR_Out <= w_flags;
            else if (w_done && w_done_s)
                SR_Out <= w_done_flags;
        end
    end

endmodule

// File: tb/tb_exe_mul_stage.sv
// tb_exe_mul_stage: directed self-checking bench for exe_mul_stage (WIDTH=32).
module tb_exe_mul_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        flush = 1'b0;
    logic [3:0]  EXE_CMD = '0;
    logic        S = 1'b0;
    logic [3:0]  SR_In = '0;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] Val_Rn = '0;
    logic [31:0] Val_Rm = '0;
    logic [31:0] Val_Ra = '0;
    logic [11:0] Shift_operand = '0;
    logic        imm = 1'b0;
    logic [23:0] Signed_EX_imm = '0;
    logic        valid_out;
    logic [31:0] ALU_Result;
    logic [31:0] Branch_Address;
    logic [3:0]  SR_Out;
    logic        SR_WE;

    int n_chk = 0;
    int n_err = 0;

    exe_mul_stage dut (
        .CLK(CLK), .RST(RST), .valid_in(valid_in), .ready_out(ready_out), .flush(flush),
        .EXE_CMD(EXE_CMD), .S(S), .SR_In(SR_In), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Val_Ra(Val_Ra),
        .Shift_operand(Shift_operand), .imm(imm), .Signed_EX_imm(Signed_EX_imm),
        .valid_out(valid_out), .ALU_Result(ALU_Result), .Branch_Address(Branch_Address),
        .SR_Out(SR_Out), .SR_WE(SR_WE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offers one op across a single rising edge; returns 1 time unit after it.
    task automatic issue(input logic [3:0] cmd, input logic s_, input logic [31:0] rn,
                         input logic [31:0] rm, input logic [11:0] so, input logic im);
        EXE_CMD = cmd; S = s_; Val_Rn = rn; Val_Rm = rm; Shift_operand = so; imm = im;
        valid_in = 1'b1;
        @(posedge CLK);
        #1 valid_in = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int seen;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_alu", ALU_Result, 32'd0);
        chk("rst_ba", Branch_Address, 32'd0);
        chk("rst_sr", 32'(SR_Out), 32'd0);
        chk("rst_srwe", 32'(SR_WE), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK);
        #1 chk("ready_after_rst", 32'(ready_out), 32'd1);

        issue(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h0, 12'h001, 1'b1);
        chk("add_ovf_res", ALU_Result, 32'h8000_0000);
        chk("add_ovf_flags", 32'(SR_Out), 32'b1001);
        chk("add_ovf_srwe", 32'(SR_WE), 32'd1);
        chk("add_ovf_valid", 32'(valid_out), 32'd1);
        idle_cycle();
        chk("idle_valid", 32'(valid_out), 32'd0);
        chk("idle_srwe", 32'(SR_WE), 32'd0);
        chk("idle_hold", ALU_Result, 32'h8000_0000);

        issue(4'b0100, 1'b1, 32'd5, 32'd5, 12'h000, 1'b0);
        chk("sub_eq_res", ALU_Result, 32'd0);
        chk("sub_eq_flags", 32'(SR_Out), 32'b0110);

        SR_In = 4'b0011;
        issue(4'b0001, 1'b1, 32'h0, 32'h0, 12'h4FF, 1'b1);
        chk("mov_rot_res", ALU_Result, 32'hFF00_0000);
        chk("mov_rot_flags", 32'(SR_Out), 32'b1011);

        issue(4'b0001, 1'b0, 32'h0, 32'h8000_0000, 12'h220, 1'b0);
        chk("lsr4", ALU_Result, 32'h0800_0000);
        issue(4'b0001, 1'b0, 32'h0, 32'h8000_0000, 12'h240, 1'b0);
        chk("asr4", ALU_Result, 32'hF800_0000);
        issue(4'b0001, 1'b0, 32'h0, 32'h0000_0001, 12'h0E0, 1'b0);
        chk("ror1", ALU_Result, 32'h8000_0000);
        issue(4'b1001, 1'b0, 32'h0, 32'h0, 12'h000, 1'b0);
        chk("mvn0", ALU_Result, 32'hFFFF_FFFF);

        SR_In = 4'b0010;
        issue(4'b0011, 1'b1, 32'd1, 32'd1, 12'h000, 1'b0);
        chk("adc_res", ALU_Result, 32'd3);
        chk("adc_flags", 32'(SR_Out), 32'b0000);
        SR_In = 4'b0000;
        issue(4'b0101, 1'b1, 32'd5, 32'd3, 12'h000, 1'b0);
        chk("sbc_res", ALU_Result, 32'd1);
        chk("sbc_flags", 32'(SR_Out), 32'b0010);

        issue(4'b0110, 1'b0, 32'hF0F0, 32'hFF00, 12'h000, 1'b0);
        chk("and", ALU_Result, 32'hF000);
        issue(4'b0111, 1'b0, 32'hF0F0, 32'hFF00, 12'h000, 1'b0);
        chk("orr", ALU_Result, 32'hFFF0);
        issue(4'b1000, 1'b0, 32'hF0F0, 32'hFF00, 12'h000, 1'b0);
        chk("eor", ALU_Result, 32'h0FF0);

        MEM_R_EN = 1'b1;
        issue(4'b0010, 1'b0, 32'h1000, 32'hDEAD, 12'hABC, 1'b0);
        chk("mem_offset", ALU_Result, 32'h1ABC);
        MEM_R_EN = 1'b0;

        PC = 32'h100; Signed_EX_imm = 24'hFFFFFE;
        issue(4'b0001, 1'b0, 32'h0, 32'h0, 12'h000, 1'b0);
        chk("branch_neg", Branch_Address, 32'h0000_00F8);
        PC = 32'h0; Signed_EX_imm = 24'h0;

        SR_In = 4'b1010;
        issue(4'b0000, 1'b1, 32'd9, 32'd9, 12'h000, 1'b0);
        chk("undef_res", ALU_Result, 32'd0);
        chk("undef_flags", 32'(SR_Out), 32'b1010);
        chk("undef_valid", 32'(valid_out), 32'd1);

        SR_In = 4'b0000;
        issue(4'b0010, 1'b0, 32'd2, 32'd2, 12'h000, 1'b0);
        chk("s0_res", ALU_Result, 32'd4);
        chk("s0_srwe", 32'(SR_WE), 32'd0);
        chk("s0_hold_sr", 32'(SR_Out), 32'b1010);

        flush = 1'b1;
        issue(4'b0010, 1'b1, 32'd7, 32'd7, 12'h000, 1'b0);
        flush = 1'b0;
        chk("flush_block_valid", 32'(valid_out), 32'd0);
        chk("flush_block_hold", ALU_Result, 32'd4);

`ifdef EXE_MUL_STAGE_MUL_EN
        begin
            int n;
            int lo;
            Val_Ra = 32'd10;
            issue(4'b1011, 1'b1, 32'd3, 32'd7, 12'h000, 1'b0);
            Val_Ra = 32'd0;
            chk("mla_ready_low", 32'(ready_out), 32'd0);
            n = 0;
            lo = ready_out ? 0 : 1;
            while (!valid_out && n < 40) begin
                @(posedge CLK);
                #1 n++;
                if (!ready_out) lo++;
            end
            chk("mla_latency", 32'(n), 32'd33);
            chk("mla_ready_cycles", 32'(lo), 32'd33);
            chk("mla_res", ALU_Result, 32'd31);
            chk("mla_flags", 32'(SR_Out), 32'b0000);
            idle_cycle();
            chk("mla_one_pulse", 32'(valid_out), 32'd0);
        end

        issue(4'b1010, 1'b0, 32'd2, 32'd3, 12'h000, 1'b0);
        repeat (9) @(posedge CLK);
        #1 flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        chk("flush_ready", 32'(ready_out), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1 if (valid_out) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        issue(4'b0010, 1'b0, 32'd2, 32'd3, 12'h000, 1'b0);
        chk("after_flush_add_valid", 32'(valid_out), 32'd1);
        chk("after_flush_add_res", ALU_Result, 32'd5);

        issue(4'b1010, 1'b1, 32'd4, 32'd4, 12'h000, 1'b0);
        repeat (4) @(posedge CLK);
        #2 RST = 1'b0;
        #1 chk("rst_mid_alu", ALU_Result, 32'd0);
        chk("rst_mid_valid", 32'(valid_out), 32'd0);
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK);
        #1 chk("rst_mid_ready", 32'(ready_out), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1 if (valid_out) seen++;
        end
        chk("rst_mid_no_valid", 32'(seen), 32'd0);
`else
        SR_In = 4'b0101;
        issue(4'b1010, 1'b1, 32'd3, 32'd7, 12'h000, 1'b0);
        chk("mul_undef_res", ALU_Result, 32'd0);
        chk("mul_undef_valid", 32'(valid_out), 32'd1);
        chk("mul_undef_flags", 32'(SR_Out), 32'b0101);
        chk("mul_undef_ready", 32'(ready_out), 32'd1);
        #2 RST = 1'b0;
        #1 chk("rst_async_sr", 32'(SR_Out), 32'd0);
        chk("rst_async_valid", 32'(valid_out), 32'd0);
        @(negedge CLK) RST = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1 if (valid_out) seen++;
        end
        chk("rst_no_valid", 32'(seen), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
